truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles each input vector is held before y is sampled; legal range 1..255.
REQ-002 clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level-sampled sweep request, acted on only in IDLE or DONE.
REQ-005 y_in  input  1  response of the downstream 4-input logic stage under test.
REQ-006 a, b, c, d  output  1 each  stimulus bits; {a,b,c,d} equals the 4-bit vector index, a = MSB.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  high while the sweep-complete results are held.
REQ-009 table_q  output  16  captured truth table; bit i = y_in sampled for vector index i.
REQ-010 ones_count  output  5  number of vectors for which y_in sampled 1 (0..16).

Function
REQ-011 The block SHALL use FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-012 IDLE: start=1 SHALL, on the next edge, clear table_q and ones_count, load index 0, load the settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-013 SETTLE: the counter SHALL decrement each cycle; at counter value 0 the FSM SHALL enter SAMPLE on the next edge, so each vector spends exactly SETTLE_CYCLES cycles in SETTLE.
REQ-014 SAMPLE (one cycle): y_in SHALL be written into table_q[index], and ones_count SHALL increment by 1 when y_in=1.
REQ-015 SAMPLE with index<15: index SHALL increment, the counter SHALL reload, and the FSM SHALL return to SETTLE.
REQ-016 SAMPLE with index=15: the FSM SHALL enter DONE; index SHALL NOT wrap, and a,b,c,d SHALL remain 4'b1111.
REQ-017 Per-vector time SHALL be SETTLE_CYCLES+1 cycles; done SHALL rise 16*(SETTLE_CYCLES+1)+1 edges after the edge that samples start.
REQ-018 busy SHALL be 1 exactly in SETTLE and SAMPLE; done SHALL be 1 exactly in DONE.
REQ-019 start SHALL be ignored in SETTLE and SAMPLE; no restart and no index change.
REQ-020 DONE SHALL hold table_q, ones_count and a..d stable indefinitely.
REQ-021 start=1 in DONE SHALL behave exactly as start=1 in IDLE: clear results and restart at index 0.
REQ-022 a..d SHALL be registered and change only on the edge that changes index.
REQ-023 y_in SHALL be sampled only in SAMPLE; y_in changes during SETTLE SHALL have no effect.

Reset
REQ-024 rst=1 SHALL, on the next edge, force IDLE, index=0 (a=b=c=d=0), busy=0, done=0, table_q=16'h0000, ones_count=0, settle counter=0.
REQ-025 rst SHALL take priority over start and over any in-progress sweep; a sweep reset mid-operation SHALL leave no partial results.

Structure
REQ-026 The shared package truth_table_pkg SHALL hold the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), the vector count constant 16, and the last-index constant 15.
REQ-027 The settle counter SHALL be a separate sub-module, settle_timer, with ports clk, rst, load, load_value and expired.
REQ-028 The FSM, index register and result registers SHALL reside in truth_table_sweeper.

Verification
REQ-029 Test 1: y_in = (a&b)|(c&d) from a behavioural model, SETTLE_CYCLES=4, one start pulse -> done rises on edge 81 after start, table_q=16'hF888, ones_count=7.
REQ-030 Test 2: y_in tied 0 -> table_q=16'h0000, ones_count=0. y_in tied 1 -> table_q=16'hFFFF, ones_count=16 (5'b10000).
REQ-031 Test 3: start held high for the whole sweep -> exactly one sweep, busy continuous for 80 cycles, index never restarts mid-sweep; when start is still high in DONE, a new sweep begins on the next edge with results cleared.
REQ-032 Test 4: rst asserted while index=7 during SETTLE -> next edge gives IDLE with all outputs 0; a subsequent start gives correct 16'hF888 with no leftover bits.
REQ-033 Test 5: y_in toggled every cycle during SETTLE but stable in SAMPLE -> table_q reflects only the SAMPLE-cycle values.
REQ-034 Test 6: SETTLE_CYCLES=1 -> per-vector time 2 cycles, done on edge 33, results match Test 1.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and sweep bounds.
package truth_table_pkg;

    // FSM encoding; values are fixed so the debug state port decodes stably.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of input vectors of a 4-input function, and the index of the last one.
    localparam int unsigned VEC_COUNT  = 16;
    localparam logic [3:0]  LAST_INDEX = 4'd15;

    // Width of the settle counter; covers SETTLE_CYCLES-1 up to 254.
    localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: loadable down-counter that stops at zero and flags expiry.
module settle_timer
    import truth_table_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a 4-bit stimulus through all 16 vectors, lets each
// settle for SETTLE_CYCLES cycles, then captures the response y_in into table_q.
//
// Handshake: start is a level request, honoured only in IDLE or DONE; busy is
// high from the edge that accepts start until the edge that enters DONE, and
// done stays high (results frozen) until the next accepted start or reset.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_q,
    output logic [4:0]  ones_count,
    output logic [1:0]  state_dbg
);

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  index_q;
    logic [15:0] tbl_q;
    logic [4:0]  ones_q;
    logic        busy_q;
    logic        done_q;

    logic        timer_load;
    logic        timer_expired;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .expired    (timer_expired)
    );

    // Reload the settle timer when a sweep starts and when moving to the next vector.
    always_comb begin
        timer_load = 1'b0;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            timer_load = 1'b1;
        end else if (state_q == SAMPLE && index_q != LAST_INDEX) begin
            timer_load = 1'b1;
        end
    end

    // Sweep FSM with index, result and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= 4'd0;
            tbl_q   <= 16'h0000;
            ones_q  <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        tbl_q   <= 16'h0000;
                        ones_q  <= 5'd0;
                        index_q <= 4'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_expired) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tbl_q[index_q] <= y_in;
                    ones_q         <= ones_q + {4'd0, y_in};
                    if (index_q == LAST_INDEX) begin
                        // Last vector: index stays at 15 so a..d hold 4'b1111.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        index_q <= index_q + 4'd1;
                        state_q <= SETTLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d} = index_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_q      = tbl_q;
    assign ones_count   = ones_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYCLES 4 and 1) driven by a
// behavioural downstream logic stage, checked against a timing/result model.
module tb_truth_table_sweeper;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT wiring (unit 0: S=4, unit 1: S=1) ----------------
    localparam int S0 = 4;
    localparam int S1 = 1;

    logic [1:0]  start_r = 2'b00;
    logic [1:0]  y_w;
    logic [1:0]  a_w, b_w, c_w, d_w, busy_w, done_w;
    logic [15:0] tbl_w  [2];
    logic [4:0]  ones_w [2];
    logic [1:0]  st_w   [2];

    // Downstream stage model: 0 = (a&b)|(c&d), 1 = const 0, 2 = const 1, 3 = random table.
    int          mode     [2] = '{0, 0};
    logic [15:0] rnd_tbl  [2] = '{16'h0, 16'h0};
    logic [1:0]  noise_en = 2'b00;
    logic        noise    = 1'b0;

    always @(posedge clk) noise <= ~noise;

    function automatic logic ref_y(input int m, input logic [3:0] i, input logic [15:0] rt);
        case (m)
            0:       return (i[3] & i[2]) | (i[1] & i[0]);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return rt[i];
        endcase
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g_stage
        assign y_w[u] = (noise_en[u] && st_w[u] != 2'd2) ? noise
                      : ref_y(mode[u], {a_w[u], b_w[u], c_w[u], d_w[u]}, rnd_tbl[u]);
    end

    truth_table_sweeper #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .y_in(y_w[0]),
        .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .table_q(tbl_w[0]),
        .ones_count(ones_w[0]), .state_dbg(st_w[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .y_in(y_w[1]),
        .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .table_q(tbl_w[1]),
        .ones_count(ones_w[1]), .state_dbg(st_w[1])
    );

    // ---------------- scoreboard helpers ----------------
    function automatic logic [3:0] obs_idx(input int u);
        return {a_w[u], b_w[u], c_w[u], d_w[u]};
    endfunction

    function automatic int settle_of(input int u);
        return (u == 0) ? S0 : S1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected table / count from the stage model, built over all 16 vectors.
    task automatic expected_results(input int u, output logic [15:0] t, output logic [4:0] n);
        t = 16'h0;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            t[i] = ref_y(mode[u], 4'(i), rnd_tbl[u]);
            n    = n + 5'(t[i]);
        end
    endtask

    task automatic check_cleared(input int u, input string tag);
        check({tag, "_state"}, 16'(st_w[u]), 16'd0);
        check({tag, "_idx"},   16'(obs_idx(u)), 16'd0);
        check({tag, "_busy"},  16'(busy_w[u]), 16'd0);
        check({tag, "_done"},  16'(done_w[u]), 16'd0);
        check({tag, "_tbl"},   tbl_w[u], 16'h0000);
        check({tag, "_ones"},  16'(ones_w[u]), 16'd0);
    endtask

    // One full sweep with cycle-by-cycle timing checks. Edge 1 samples start;
    // edge k (1..P*16) shows vector (k-1)/P with phase (k-1)%P, P = S+1;
    // edge P*16+1 shows DONE.
    task automatic run_sweep(input int u, input bit hold, input string tag);
        int          s;
        int          p;
        int          total;
        logic [15:0] et;
        logic [4:0]  en;
        s     = settle_of(u);
        p     = s + 1;
        total = 16 * p + 1;
        expected_results(u, et, en);
        start_r[u] = 1'b1;
        for (int k = 1; k <= total; k++) begin
            tick();
            if (!hold) start_r[u] = 1'b0;
            if (k < total) begin
                check($sformatf("%s_idx_e%0d", tag, k), 16'(obs_idx(u)), 16'((k - 1) / p));
                check($sformatf("%s_st_e%0d", tag, k), 16'(st_w[u]),
                      ((k - 1) % p < s) ? 16'd1 : 16'd2);
                check($sformatf("%s_busy_e%0d", tag, k), 16'(busy_w[u]), 16'd1);
                check($sformatf("%s_done_e%0d", tag, k), 16'(done_w[u]), 16'd0);
            end else begin
                check($sformatf("%s_done_rise_e%0d", tag, k), 16'(done_w[u]), 16'd1);
                check({tag, "_busy_end"}, 16'(busy_w[u]), 16'd0);
                check({tag, "_idx_end"},  16'(obs_idx(u)), 16'hF);
                check({tag, "_tbl"},      tbl_w[u], et);
                check({tag, "_ones"},     16'(ones_w[u]), 16'(en));
            end
        end
        if (!hold) begin
            // Results must stay frozen while idle in DONE.
            repeat (4) begin
                tick();
                check({tag, "_hold_done"}, 16'(done_w[u]), 16'd1);
                check({tag, "_hold_tbl"},  tbl_w[u], et);
                check({tag, "_hold_ones"}, 16'(ones_w[u]), 16'(en));
                check({tag, "_hold_idx"},  16'(obs_idx(u)), 16'hF);
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] et;
        logic [4:0]  en;

        repeat (2) tick();
        check_cleared(0, "reset0");
        check_cleared(1, "reset1");
        rst = 1'b0;
        tick();

        // Reference function, constant-result sanity on the model itself via the DUT.
        mode[0] = 0;
        run_sweep(0, 1'b0, "t1_func");
        check("t1_tbl_const", tbl_w[0], 16'hF888);
        check("t1_ones_const", 16'(ones_w[0]), 16'd7);

        // Constant responses; restart from DONE clears results.
        mode[0] = 1;
        run_sweep(0, 1'b0, "t2_zero");
        mode[0] = 2;
        run_sweep(0, 1'b0, "t2_one");
        check("t2_ones16", 16'(ones_w[0]), 16'h10);

        // start held through the sweep, then still high in DONE -> restart.
        mode[0] = 0;
        run_sweep(0, 1'b1, "t3_hold");
        tick();
        check("t3_restart_state", 16'(st_w[0]), 16'd1);
        check("t3_restart_idx",   16'(obs_idx(0)), 16'd0);
        check("t3_restart_busy",  16'(busy_w[0]), 16'd1);
        check("t3_restart_done",  16'(done_w[0]), 16'd0);
        check("t3_restart_tbl",   tbl_w[0], 16'h0000);
        check("t3_restart_ones",  16'(ones_w[0]), 16'd0);
        start_r[0] = 1'b0;
        pulse_reset();
        check_cleared(0, "t3_reset");

        // Reset mid-sweep at index 7 during SETTLE.
        mode[0] = 2;
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        repeat (36) tick();
        check("t4_pre_idx",   16'(obs_idx(0)), 16'd7);
        check("t4_pre_state", 16'(st_w[0]), 16'd1);
        check("t4_pre_ones",  16'(ones_w[0]), 16'd7);
        rst = 1'b1;
        start_r[0] = 1'b1;
        tick();
        rst = 1'b0;
        start_r[0] = 1'b0;
        check_cleared(0, "t4_reset");
        mode[0] = 0;
        run_sweep(0, 1'b0, "t4_after");

        // Response toggling during SETTLE, stable in SAMPLE.
        noise_en[0] = 1'b1;
        run_sweep(0, 1'b0, "t5_noise");
        noise_en[0] = 1'b0;

        // Random 4-input functions.
        mode[0] = 3;
        for (int r = 0; r < 3; r++) begin
            rnd_tbl[0] = 16'($urandom());
            repeat ($urandom_range(0, 3)) tick();
            run_sweep(0, 1'b0, $sformatf("rnd%0d", r));
        end

        // Minimum settle time on the second instance.
        mode[1] = 0;
        run_sweep(1, 1'b0, "t6_s1");
        expected_results(0, et, en);
        mode[1] = 3;
        rnd_tbl[1] = 16'($urandom());
        run_sweep(1, 1'b0, "t6_rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
